mulcnt_sched: RTL and testbench
===============================

Name: mulcnt_sched

Overview:
Round-robin scheduler that shares one multiply/popcount engine (24x24 multiply, low 32 bits of the product as W, ones count of W as L, overflow-free flag) between NREQ requesters. It grants one requester at a time, latches that requester's operands, and starts the engine. It then waits for completion or timeout and broadcasts the tagged result. It sits between the GPIO/bus-side requesters and the engine, and keeps a 16-bit completed-operation counter.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester id (ceil log2 NREQ, min 1)
TIMEOUT, 64, max cycles waited for eng_done before aborting (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cfg_en  in  1  1 = new grants allowed; 0 = finish in-flight op, then hold in IDLE
req  in  NREQ  per-requester request level, held until matching gnt
req_a1  in  NREQ*24  packed operand A1, slice i = [24*i+23:24*i]
req_a2  in  NREQ*24  packed operand A2, same packing
gnt  out  NREQ  one-hot, one-cycle grant pulse
eng_start  out  1  one-cycle start pulse to engine
eng_a1  out  24  latched A1 to engine, stable from eng_start until the next grant
eng_a2  out  24  latched A2 to engine
eng_done  in  1  engine completion pulse
eng_w  in  32  engine result W, valid with eng_done
eng_l  in  6  engine ones count, valid with eng_done
eng_ok  in  1  engine flag: product[47:32]==0
rsp_valid  out  1  one-cycle result pulse
rsp_id  out  IDW  requester the result belongs to
rsp_w  out  32  result W
rsp_l  out  6  result L
rsp_ok  out  1  copy of eng_ok; 0 on timeout
rsp_err  out  1  1 = timeout abort
busy  out  1  1 in any state but IDLE
op_count  out  16  completed (non-error) operations, wraps 0xFFFF->0

Behaviour:
- Reset (async, immediate) values: state=IDLE; gnt=0; eng_start=0; eng_a1=0; eng_a2=0; rsp_*=0; busy=0; op_count=0; rr pointer=0; timeout counter=0.
- Reset while an op is in flight abandons it. No rsp is emitted. Any late eng_done after reset is released is ignored, because state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if cfg_en=1 and req!=0, select the winner by round robin, searching from index ptr upward with wrap. Go to ISSUE.
- ISSUE (1 cycle): gnt[winner]=1, eng_start=1, eng_a1/eng_a2 <= winner's slices, id latched, ptr <= winner+1 mod NREQ. Go to WAIT.
  - Latency: req sampled high in cycle N means gnt and eng_start are asserted in cycle N+1.
- WAIT: timeout counter increments each cycle, starting from 0 on entry.
  - eng_done=1: latch eng_w, eng_l and eng_ok into rsp_*, rsp_err=0. Go to RESP.
  - Otherwise, if counter reaches TIMEOUT-1: rsp_w=0, rsp_l=0, rsp_ok=0, rsp_err=1. Go to RESP.
  - If eng_done and timeout happen in the same cycle, done wins.
- RESP (1 cycle): rsp_valid=1, rsp_id=latched id. op_count += 1 only when rsp_err=0. Return to IDLE.
- rsp_w/l/ok/err/id hold their values after the RESP pulse until the next RESP.
- Minimum cycle from request to next grant: IDLE -> ISSUE -> WAIT (>=1) -> RESP -> IDLE, so at most one grant per 4 cycles.
- eng_done outside WAIT is ignored.
- A requester must hold req high with stable operands until it sees its gnt, and must drop req the cycle after gnt. If req is still high in IDLE, that is a new request.
- cfg_en is sampled only in IDLE. Deasserting it mid-op does not abort the op.
- If req drops before its grant, no grant is issued; no error.
- op_count wraps modulo 2^16.

Test Plan:
- Single op: req=0001, A1=0x000003, A2=0x000005; engine returns W=15, L=4, ok=1 after 3 cycles -> gnt=0001 exactly 1 cycle after req; eng_a1=3, eng_a2=5; rsp_valid with id=0, w=15, l=4, ok=1, err=0; op_count=1.
- Round robin: req=1111 held, each requester dropping after its own gnt -> grant order 0,1,2,3. Then req=1001 -> grant order 0,3, because ptr=0 after wrap.
- Timeout: TIMEOUT=64, engine never responds -> rsp_valid 64 cycles after entering WAIT; err=1, ok=0, w=0; op_count unchanged. A late eng_done afterwards is ignored.
- Done/timeout collision: eng_done asserted on cycle TIMEOUT-1 of WAIT with W=0xFFFFFFFF, L=32 -> err=0, w=0xFFFFFFFF, l=32.
- cfg_en and overflow flag: cfg_en=0 with req=0010 -> no gnt for 10 cycles. Set cfg_en=1 -> gnt=0010 the next cycle. Engine returns ok=0 for A1=A2=0xFFFFFF -> rsp_ok=0 and op_count still increments.
- Async reset mid-WAIT: assert reset -> gnt, busy and rsp_* are 0 immediately; op_count=0; no rsp_valid after reset is released.

Source files
------------

// File: rtl/mulcnt_sched.sv
// mulcnt_sched: round-robin scheduler sharing one multiply/popcount engine
// between NREQ requesters. It grants one requester at a time, latches that
// requester's operands, pulses eng_start, and then waits for eng_done or a
// timeout. The tagged result goes out as a one-cycle rsp_valid pulse.
// A 16-bit counter counts the operations that completed without error.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), async active-high reset
//   cfg_en_i                allow new grants (sampled in IDLE only)
//   req_i[NREQ]             request levels
//   req_a1_i / req_a2_i     packed 24-bit operands, slice i = [24*i +: 24]
//   gnt_o[NREQ]             one-hot one-cycle grant pulse
//   eng_start_o             one-cycle start pulse to the engine
//   eng_a1_o / eng_a2_o     operands latched at grant
//   eng_done_i, eng_w_i, eng_l_i, eng_ok_i   engine completion and result
//   rsp_valid_o             one-cycle result pulse
//   rsp_id_o, rsp_w_o, rsp_l_o, rsp_ok_o, rsp_err_o   result (held until next)
//   busy_o                  high in any state other than IDLE
//   op_count_o              completed non-error operations, wraps at 2^16
module mulcnt_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cfg_en_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*24-1:0] req_a1_i,
  input  logic [NREQ*24-1:0] req_a2_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               eng_start_o,
  output logic [23:0]        eng_a1_o,
  output logic [23:0]        eng_a2_o,
  input  logic               eng_done_i,
  input  logic [31:0]        eng_w_i,
  input  logic [5:0]         eng_l_i,
  input  logic               eng_ok_i,
  output logic               rsp_valid_o,
  output logic [IDW-1:0]     rsp_id_o,
  output logic [31:0]        rsp_w_o,
  output logic [5:0]         rsp_l_o,
  output logic               rsp_ok_o,
  output logic               rsp_err_o,
  output logic               busy_o,
  output logic [15:0]        op_count_o
);

  localparam int CNTW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [CNTW-1:0] tmo_cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic            eng_start_q;
  logic [23:0]     eng_a1_q;
  logic [23:0]     eng_a2_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [31:0]     rsp_w_q;
  logic [5:0]      rsp_l_q;
  logic            rsp_ok_q;
  logic            rsp_err_q;
  logic            busy_q;
  logic [15:0]     op_count_q;

  // Unpack the operand buses into per-requester arrays.
  logic [23:0] a1_arr [NREQ];
  logic [23:0] a2_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a1_arr[gi] = req_a1_i[24*gi +: 24];
      assign a2_arr[gi] = req_a2_i[24*gi +: 24];
    end
  endgenerate

  // Round-robin search starting at ptr_q, upward with wrap. The loop runs
  // from the farthest offset down, so the nearest requester to the pointer
  // is the last one assigned and therefore wins.
  logic            win_found_d;
  logic [IDW-1:0]  win_idx_d;
  logic [IDW:0]    cand_d;
  logic [NREQ-1:0] gnt_onehot_d;
  logic [IDW-1:0]  ptr_d;

  always_comb begin
    win_found_d  = 1'b0;
    win_idx_d    = '0;
    cand_d       = '0;
    gnt_onehot_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_d = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_d >= (IDW+1)'(NREQ)) begin
        cand_d = cand_d - (IDW+1)'(NREQ);
      end
      if (req_i[cand_d[IDW-1:0]]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d[IDW-1:0];
      end
    end
    gnt_onehot_d[win_idx_d] = 1'b1;
    ptr_d = (win_idx_d == IDW'(NREQ - 1)) ? '0 : win_idx_d + IDW'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      tmo_cnt_q   <= '0;
      gnt_q       <= '0;
      eng_start_q <= 1'b0;
      eng_a1_q    <= '0;
      eng_a2_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_w_q     <= '0;
      rsp_l_q     <= '0;
      rsp_ok_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      gnt_q       <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_en_i && win_found_d) begin
            gnt_q       <= gnt_onehot_d;
            eng_start_q <= 1'b1;
            eng_a1_q    <= a1_arr[win_idx_d];
            eng_a2_q    <= a2_arr[win_idx_d];
            id_q        <= win_idx_d;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          // Completion is checked first, so done wins a tie with the timeout.
          if (eng_done_i) begin
            rsp_w_q     <= eng_w_i;
            rsp_l_q     <= eng_l_i;
            rsp_ok_q    <= eng_ok_i;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (tmo_cnt_q == CNTW'(TIMEOUT - 1)) begin
            rsp_w_q     <= '0;
            rsp_l_q     <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNTW'(1);
          end
        end
        RESP: begin
          if (!rsp_err_q) begin
            op_count_q <= op_count_q + 16'd1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign eng_start_o = eng_start_q;
  assign eng_a1_o    = eng_a1_q;
  assign eng_a2_o    = eng_a2_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_w_o     = rsp_w_q;
  assign rsp_l_o     = rsp_l_q;
  assign rsp_ok_o    = rsp_ok_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;
  assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_mulcnt_sched.sv
// Testbench for mulcnt_sched: directed scenarios plus randomized traffic
// checked against a transaction-level reference model (round-robin by index
// arithmetic, result timing derived from the engine delay, arithmetic result).
module tb_mulcnt_sched;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_en;
  logic [NREQ-1:0]    req;
  logic [NREQ*24-1:0] req_a1;
  logic [NREQ*24-1:0] req_a2;
  logic [NREQ-1:0]    gnt;
  logic               eng_start;
  logic [23:0]        eng_a1;
  logic [23:0]        eng_a2;
  logic               eng_done;
  logic [31:0]        eng_w;
  logic [5:0]         eng_l;
  logic               eng_ok;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_w;
  logic [5:0]         rsp_l;
  logic               rsp_ok;
  logic               rsp_err;
  logic               busy;
  logic [15:0]        op_count;

  always #5 clk = ~clk;

  mulcnt_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset), .cfg_en_i(cfg_en), .req_i(req),
    .req_a1_i(req_a1), .req_a2_i(req_a2), .gnt_o(gnt), .eng_start_o(eng_start),
    .eng_a1_o(eng_a1), .eng_a2_o(eng_a2), .eng_done_i(eng_done), .eng_w_i(eng_w),
    .eng_l_i(eng_l), .eng_ok_i(eng_ok), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
    .rsp_w_o(rsp_w), .rsp_l_o(rsp_l), .rsp_ok_o(rsp_ok), .rsp_err_o(rsp_err),
    .busy_o(busy), .op_count_o(op_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int          e = 0;            // posedge index
  bit          in_flight = 0;    // an op is between grant and end of its result cycle
  int          rsp_edge = -1;    // edge after which rsp_valid is expected
  int          done_edge = -1;   // edge after which the engine drives eng_done
  int          m_ptr = 0;
  logic [15:0] m_count = '0;
  int          exp_id;
  logic [31:0] exp_w;
  logic [5:0]  exp_l;
  logic        exp_ok, exp_err;
  logic [31:0] eng_w_m;
  logic [5:0]  eng_l_m;
  logic        eng_ok_m;
  bit          rand_on = 0;
  int          delay_sel = 2;    // <0 random, 0 engine never answers, else fixed delay
  logic [NREQ-1:0] gnt_prev = '0;
  int          gq[$];
  int          obs_gnt_edge = -1;
  int          obs_rsp_edge = -1;

  function automatic logic [23:0] rand24();
    return ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
  endfunction

  task automatic set_req(input int i, input logic [23:0] a1, input logic [23:0] a2);
    req[i]            = 1'b1;
    req_a1[24*i +: 24] = a1;
    req_a2[24*i +: 24] = a2;
  endtask

  // One clock: drive inputs after the edge, check outputs at the negedge.
  task automatic step();
    logic [NREQ-1:0]    s_req;
    logic               s_cfg;
    logic [NREQ*24-1:0] s_a1, s_a2;
    logic [NREQ-1:0]    exp_gnt;
    logic [47:0]        prod;
    bit                 prev_if;
    int                 win, d;
    s_req = req; s_cfg = cfg_en; s_a1 = req_a1; s_a2 = req_a2;
    @(posedge clk);
    #1;
    e++;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_prev[i]) begin
        req[i] = 1'b0;
      end else if (rand_on) begin
        if (!req[i] && $urandom_range(0, 3) == 0) set_req(i, rand24(), rand24());
        else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
      end
    end
    if (rand_on) begin
      if (cfg_en) cfg_en = ($urandom_range(0, 99) != 0);
      else        cfg_en = ($urandom_range(0, 9) == 0);
    end
    if (e == done_edge) begin
      eng_done = 1'b1; eng_w = eng_w_m; eng_l = eng_l_m; eng_ok = eng_ok_m;
    end else begin
      eng_done = (!in_flight && rand_on && $urandom_range(0, 9) == 0);
      eng_w = $urandom; eng_l = 6'($urandom); eng_ok = 1'($urandom);
    end
    @(negedge clk);
    prev_if = in_flight;
    if (in_flight && e == rsp_edge + 1) begin
      in_flight = 0;
      if (!exp_err) m_count = m_count + 16'd1;
    end
    exp_gnt = '0;
    win = -1;
    if (!prev_if && s_cfg && s_req != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && s_req[idx]) win = idx;
      end
      exp_gnt[win] = 1'b1;
    end
    check_eq("gnt", gnt, exp_gnt);
    check_eq("eng_start", eng_start, (win >= 0));
    if (gnt != 0) begin
      obs_gnt_edge = e;
      for (int k = 0; k < NREQ; k++) if (gnt[k]) gq.push_back(k);
    end
    if (win >= 0) begin
      check_eq("eng_a1", eng_a1, s_a1[24*win +: 24]);
      check_eq("eng_a2", eng_a2, s_a2[24*win +: 24]);
      in_flight = 1;
      m_ptr = (win + 1) % NREQ;
      prod = 48'(s_a1[24*win +: 24]) * 48'(s_a2[24*win +: 24]);
      eng_w_m  = prod[31:0];
      eng_l_m  = 6'($countones(prod[31:0]));
      eng_ok_m = (prod[47:32] == 16'd0);
      if (delay_sel < 0) begin
        case ($urandom_range(0, 19))
          0:       d = 66;
          1:       d = 64;
          default: d = $urandom_range(1, 6);
        endcase
      end else begin
        d = delay_sel;
      end
      exp_id = win;
      if (d >= 1 && d <= TIMEOUT) begin
        rsp_edge = e + d + 1;
        exp_w = eng_w_m; exp_l = eng_l_m; exp_ok = eng_ok_m; exp_err = 1'b0;
      end else begin
        rsp_edge = e + TIMEOUT + 1;
        exp_w = '0; exp_l = '0; exp_ok = 1'b0; exp_err = 1'b1;
      end
      done_edge = (d > 0) ? e + d : -1;
    end
    check_eq("busy", busy, in_flight);
    check_eq("rsp_valid", rsp_valid, (in_flight && e == rsp_edge));
    if (rsp_valid) obs_rsp_edge = e;
    if (in_flight && e == rsp_edge) begin
      $display("rsp @%0d id=%0d w=%08h l=%0d ok=%0b err=%0b", e, rsp_id, rsp_w, rsp_l, rsp_ok, rsp_err);
      check_eq("rsp_id", rsp_id, exp_id);
      check_eq("rsp_w", rsp_w, exp_w);
      check_eq("rsp_l", rsp_l, exp_l);
      check_eq("rsp_ok", rsp_ok, exp_ok);
      check_eq("rsp_err", rsp_err, exp_err);
    end
    check_eq("op_count", op_count, m_count);
    gnt_prev = gnt;
  endtask

  // Step until every pending request has been served and the DUT is idle.
  task automatic run_ops(input int max_steps);
    int n;
    n = 0;
    while ((in_flight || req != 0) && n < max_steps) begin
      step();
      n++;
    end
    check_eq("ops_bound", (n < max_steps), 1'b1);
  endtask

  initial begin
    logic [15:0] saved;
    int start_e;
    reset = 1'b1; cfg_en = 1'b1; req = '0; req_a1 = '0; req_a2 = '0;
    eng_done = 1'b0; eng_w = '0; eng_l = '0; eng_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_gnt", gnt, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_op_count", op_count, 0);
    check_eq("reset_eng_a1", eng_a1, 0);
    reset = 1'b0;

    // Single op: 3*5 = 15, popcount 4.
    delay_sel = 3; gq.delete();
    set_req(0, 24'd3, 24'd5);
    start_e = e;
    run_ops(50);
    check_eq("single_gnt_latency", obs_gnt_edge - start_e, 1);
    check_eq("single_eng_a1", eng_a1, 24'd3);
    check_eq("single_eng_a2", eng_a2, 24'd5);
    check_eq("single_w", rsp_w, 32'd15);
    check_eq("single_l", rsp_l, 6'd4);
    check_eq("single_ok", rsp_ok, 1'b1);
    check_eq("single_count", op_count, 16'd1);

    // Round robin: pointer now 1, so four requests grant 1,2,3,0.
    // First wrap the pointer back to 0 with a grant of requester 3.
    delay_sel = 2;
    set_req(3, rand24(), rand24());
    run_ops(50);
    gq.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, rand24(), rand24());
    run_ops(200);
    check_eq("rr_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) check_eq("rr_order", gq[i], i);
    gq.delete();
    set_req(0, rand24(), rand24());
    set_req(3, rand24(), rand24());
    run_ops(200);
    check_eq("rr2_count", gq.size(), 2);
    if (gq.size() == 2) begin
      check_eq("rr2_first", gq[0], 0);
      check_eq("rr2_second", gq[1], 3);
    end

    // Timeout with a late done that must be ignored.
    delay_sel = 66;
    saved = m_count;
    set_req(2, 24'd7, 24'd9);
    run_ops(200);
    check_eq("tmo_latency", obs_rsp_edge - obs_gnt_edge, TIMEOUT + 1);
    check_eq("tmo_err", rsp_err, 1'b1);
    check_eq("tmo_ok", rsp_ok, 1'b0);
    check_eq("tmo_w", rsp_w, 32'd0);
    repeat (6) step();
    check_eq("tmo_count", op_count, saved);

    // Done on the final wait cycle: 196611 * 21845 = 0xFFFFFFFF.
    delay_sel = TIMEOUT;
    set_req(1, 24'd196611, 24'd21845);
    run_ops(200);
    check_eq("coll_err", rsp_err, 1'b0);
    check_eq("coll_w", rsp_w, 32'hFFFFFFFF);
    check_eq("coll_l", rsp_l, 6'd32);

    // cfg_en low holds the grant; overflowing product gives ok=0 but counts.
    delay_sel = 4; gq.delete();
    cfg_en = 1'b0;
    set_req(1, 24'hFFFFFF, 24'hFFFFFF);
    repeat (10) step();
    check_eq("cfg_hold", gq.size(), 0);
    cfg_en = 1'b1;
    saved = m_count;
    start_e = e;
    run_ops(50);
    check_eq("cfg_gnt_latency", obs_gnt_edge - start_e, 1);
    check_eq("ovf_ok", rsp_ok, 1'b0);
    check_eq("ovf_count", op_count, saved + 16'd1);

    // Async reset in the middle of WAIT; the late done must not produce a result.
    delay_sel = 20;
    set_req(2, 24'd11, 24'd13);
    start_e = e;
    while (!(in_flight && e >= obs_gnt_edge + 5) && e < start_e + 50) step();
    check_eq("rst_setup", in_flight, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_w", rsp_w, 0);
    check_eq("rst_rsp_l", rsp_l, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_op_count", op_count, 0);
    check_eq("rst_eng_a1", eng_a1, 0);
    in_flight = 0; m_count = '0; m_ptr = 0; req = '0; gnt_prev = '0;
    step();
    step();
    reset = 1'b0;
    repeat (25) step();

    // Randomized traffic.
    delay_sel = -1;
    rand_on = 1;
    repeat (3000) step();
    rand_on = 0;
    cfg_en = 1'b1;
    req = '0;
    run_ops(200);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
